// File: rtl/scratchpad_sram_ctrl.sv
// Power-gated scratchpad SRAM controller: OFF/WAKE/ACTIVE/RET power FSM,
// byte-enable access port, optional March C- MBIST (define SRAM_MBIST_EN).
module scratchpad_sram_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 2048,
  parameter int WAKE_CYCLES = 4,
  localparam int BE_W = DATA_W / 8,
  localparam int AW   = $clog2(DEPTH * BE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              pd_en,
  input  logic              ret_en,
  input  logic              mbist_start,
  output logic              mbist_busy,
  output logic              mbist_done,
  output logic              mbist_fail,
  output logic [AW-1:0]     mbist_fail_addr
);

  localparam int OW = $clog2(BE_W);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {OFF, WAKE, ACTIVE, RET} pstate_t;

  pstate_t             state, state_n;
  logic [CW-1:0]       wcnt, wcnt_n;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [IW-1:0]       idx;
  logic                accept;
  logic                bist_busy;

  wire unused_ok = &{1'b0, req_addr, mbist_start};

  assign idx       = req_addr[AW-1:OW];
  assign req_ready = (state == ACTIVE) && !ret_en && !bist_busy;
  assign accept    = req_valid && req_ready && !rst;

  // Power state register and wake-up counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  // Power next-state; pd_en low overrides everything
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    unique case (state)
      OFF: if (pd_en) begin
        state_n = WAKE;
        wcnt_n  = '0;
      end
      WAKE: if (wcnt == CW'(WAKE_CYCLES - 1)) state_n = ACTIVE;
            else wcnt_n = wcnt + CW'(1);
      ACTIVE: if (ret_en) state_n = RET;
      RET: if (!ret_en) begin
        state_n = WAKE;
        wcnt_n  = '0;
      end
      default: state_n = OFF;
    endcase
    if (!pd_en) state_n = OFF;
  end

  // Read response; data holds until the next read
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept && !req_we;
      if (accept && !req_we) rsp_rdata <= mem[idx];
    end
  end

`ifdef SRAM_MBIST_EN
  logic              busy, done, fail, sub, ops_end, chk, chk_exp;
  logic [AW-1:0]     fail_addr;
  logic [2:0]        elem;
  logic [IW-1:0]     baddr, chk_addr;
  logic [DATA_W-1:0] rd_q, mem_q;
  logic              run, two, down, rpat, wpat, is_rd, bist_we;
  logic              abort, miss, adv, last_addr;

  assign mem_q     = mem[baddr];
  assign run       = busy && !ops_end;
  assign two       = (elem >= 3'd1) && (elem <= 3'd4);
  assign down      = (elem == 3'd3) || (elem == 3'd4);
  assign rpat      = (elem == 3'd2) || (elem == 3'd4);
  assign wpat      = (elem == 3'd1) || (elem == 3'd3);
  assign is_rd     = run && ((elem == 3'd5) || (two && !sub));
  assign abort     = busy && (!pd_en || ret_en);
  assign miss      = chk && (rd_q != {DATA_W{chk_exp}});
  assign bist_we   = run && !is_rd && !abort && !miss && !rst;
  assign adv       = !(two && !sub);
  assign last_addr = down ? (baddr == '0) : (baddr == IW'(DEPTH - 1));
  assign bist_busy = busy;

  assign mbist_busy      = busy;
  assign mbist_done      = done;
  assign mbist_fail      = fail;
  assign mbist_fail_addr = fail_addr;

  // March C- sequencer: one op per cycle, reads compared a cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0; done <= 1'b0; fail <= 1'b0;
      fail_addr <= '0; elem <= '0; sub <= 1'b0;
      baddr <= '0; ops_end <= 1'b0; chk <= 1'b0;
      chk_exp <= 1'b0; chk_addr <= '0; rd_q <= '0;
    end else if (!busy) begin
      if (mbist_start && state == ACTIVE) begin
        busy <= 1'b1; done <= 1'b0; fail <= 1'b0;
        fail_addr <= '0; elem <= '0; sub <= 1'b0;
        baddr <= '0; ops_end <= 1'b0; chk <= 1'b0;
      end
    end else if (abort) begin
      busy <= 1'b0; done <= 1'b1; fail <= 1'b1;
      fail_addr <= AW'(baddr) << OW;
      chk <= 1'b0;
    end else if (miss) begin
      busy <= 1'b0; done <= 1'b1; fail <= 1'b1;
      fail_addr <= AW'(chk_addr) << OW;
      chk <= 1'b0;
    end else if (ops_end) begin
      busy <= 1'b0; done <= 1'b1; chk <= 1'b0;
    end else begin
      chk <= is_rd;
      if (is_rd) begin
        rd_q     <= mem_q;
        chk_exp  <= rpat;
        chk_addr <= baddr;
      end
      if (!adv) begin
        sub <= 1'b1;
      end else begin
        sub <= 1'b0;
        if (last_addr) begin
          if (elem == 3'd5) ops_end <= 1'b1;
          else begin
            elem  <= elem + 3'd1;
            baddr <= (elem == 3'd2 || elem == 3'd3) ? '1 : '0;
          end
        end else begin
          baddr <= down ? baddr - IW'(1) : baddr + IW'(1);
        end
      end
    end
  end

  // Array write port: MBIST has priority, host writes only when accepted
  always_ff @(posedge clk) begin
    if (bist_we) begin
      mem[baddr] <= {DATA_W{wpat}};
    end else if (accept && req_we) begin
      for (int b = 0; b < BE_W; b++)
        if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
    end
  end
`else
  assign bist_busy       = 1'b0;
  assign mbist_busy      = 1'b0;
  assign mbist_done      = 1'b0;
  assign mbist_fail      = 1'b0;
  assign mbist_fail_addr = '0;

  // Array write port: host writes only when accepted
  always_ff @(posedge clk) begin
    if (accept && req_we) begin
      for (int b = 0; b < BE_W; b++)
        if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
    end
  end
`endif

endmodule

// File: tb/tb_scratchpad_sram_ctrl.sv
// Self-checking bench for scratchpad_sram_ctrl: vector table plus
// directed power, retention, reset and MBIST sequences.
module tb_scratchpad_sram_ctrl;

`ifdef SRAM_MBIST_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 2048;
`endif
  localparam int AW = $clog2(DEPTH * 4);
  localparam logic [AW-1:0] TOP = AW'(DEPTH * 4 - 4);

  logic          clk = 1'b0;
  logic          rst, req_valid, req_ready, req_we;
  logic [3:0]    req_be;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata, rsp_rdata;
  logic          rsp_valid, pd_en, ret_en, mbist_start;
  logic          mbist_busy, mbist_done, mbist_fail;
  logic [AW-1:0] mbist_fail_addr;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp;
  } vec_t;
  vec_t vecs[13];

  always #5 clk = ~clk;

  scratchpad_sram_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .WAKE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .pd_en(pd_en), .ret_en(ret_en), .mbist_start(mbist_start),
    .mbist_busy(mbist_busy), .mbist_done(mbist_done),
    .mbist_fail(mbist_fail), .mbist_fail_addr(mbist_fail_addr)
  );

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Scoreboard: every read response is matched against the queued value
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else check("rsp_rdata", 64'(rsp_rdata), 64'(sb.pop_front()));
    end
  end

  task automatic do_req(logic we, logic [3:0] be, logic [AW-1:0] a,
                        logic [31:0] wd, logic [31:0] exp);
    check("req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_be = be;
    req_addr = a; req_wdata = wd;
    if (!we) sb.push_back(exp);
    cyc();
    req_valid = 1'b0;
    check(we ? "rsp_after_wr" : "rsp_latency", 64'(rsp_valid), 64'(!we));
  endtask

  task automatic wait_ready(string nm);
    int n;
    cyc();
    check({nm, "_low"}, 64'(req_ready), 64'd0);
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    check(nm, 64'(n), 64'd4);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (mbist_done !== 1'b1 && n < 1000) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int viol, n;
    vecs[0]  = '{1'b1, 4'hF, AW'('h10), 32'hAABBCCDD, 32'h0};
    vecs[1]  = '{1'b1, 4'h5, AW'('h10), 32'h11223344, 32'h0};
    vecs[2]  = '{1'b0, 4'h0, AW'('h10), 32'h0,        32'hAA22CC44};
    vecs[3]  = '{1'b1, 4'hF, AW'('h20), 32'hDEADBEEF, 32'h0};
    vecs[4]  = '{1'b0, 4'h0, AW'('h20), 32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b1, 4'h8, AW'('h20), 32'h01000000, 32'h0};
    vecs[6]  = '{1'b0, 4'h0, AW'('h21), 32'h0,        32'h01ADBEEF};
    vecs[7]  = '{1'b1, 4'h2, AW'('h23), 32'h00005500, 32'h0};
    vecs[8]  = '{1'b0, 4'h0, AW'('h22), 32'h0,        32'h01AD55EF};
    vecs[9]  = '{1'b1, 4'hF, AW'('h00), 32'h00000000, 32'h0};
    vecs[10] = '{1'b1, 4'h0, AW'('h00), 32'hFFFFFFFF, 32'h0};
    vecs[11] = '{1'b0, 4'h0, AW'('h00), 32'h0,        32'h00000000};
    vecs[12] = '{1'b0, 4'h0, AW'('h10), 32'h0,        32'hAA22CC44};

    rst = 1'b1; pd_en = 1'b0; ret_en = 1'b0; mbist_start = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_be = '0;
    req_addr = '0; req_wdata = '0;
    cyc(); cyc();
    check("reset_outputs",
          64'({req_ready, rsp_valid, rsp_rdata, mbist_busy,
               mbist_done, mbist_fail, mbist_fail_addr}), 64'd0);

    rst = 1'b0; pd_en = 1'b1;
    wait_ready("powerup");

    foreach (vecs[i])
      do_req(vecs[i].we, vecs[i].be, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp);

    do_req(1'b1, 4'hF, AW'('h40), 32'h55555555, 32'h0);
    check("rdata_hold", 64'(rsp_rdata), 64'hAA22CC44);

    do_req(1'b1, 4'hF, TOP, 32'h12345678, 32'h0);
    ret_en = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
    req_addr = AW'('h10); req_wdata = 32'hFFFFFFFF;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (req_ready !== 1'b0) viol++;
    end
    check("ret_ready_low", 64'(viol), 64'd0);
    ret_en = 1'b0;
    wait_ready("ret_wake");
    req_valid = 1'b0;
    do_req(1'b0, 4'h0, TOP, 32'h0, 32'h12345678);
    do_req(1'b0, 4'h0, AW'('h10), 32'h0, 32'hAA22CC44);

    pd_en = 1'b0;
    do_req(1'b0, 4'h0, AW'('h20), 32'h0, 32'h01AD55EF);
    check("off_ready", 64'(req_ready), 64'd0);

    pd_en = 1'b1;
    wait_ready("repower");
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'('h10); rst = 1'b1;
    cyc();
    check("rst_mid_rsp", 64'(rsp_valid), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd0);
    rst = 1'b0; req_valid = 1'b0;
    wait_ready("post_rst");
    check("rst_no_rsp", 64'(rsp_valid), 64'd0);

`ifdef SRAM_MBIST_EN
    mbist_start = 1'b1;
    cyc();
    mbist_start = 1'b0;
    check("bist_busy", 64'({mbist_busy, req_ready}), 64'b10);
    wait_done(n);
    check("bist_pass_cycles", 64'(n), 64'(10 * DEPTH + 1));
    check("bist_pass_fail", 64'({mbist_fail, mbist_busy}), 64'd0);

    mbist_start = 1'b1;
    cyc();
    mbist_start = 1'b0;
    n = 0;
    while (mbist_done !== 1'b1 && n < 1000) begin
      if (dut.baddr == 4'd5) force dut.mem_q[0] = 1'b0;
      else release dut.mem_q[0];
      cyc();
      n++;
    end
    release dut.mem_q[0];
    check("fault_flags", 64'({mbist_done, mbist_fail, mbist_busy}), 64'b110);
    check("fault_addr", 64'(mbist_fail_addr), 64'h14);

    mbist_start = 1'b1;
    cyc();
    mbist_start = 1'b0;
    for (int i = 0; i < 30; i++) cyc();
    check("abort_running", 64'(mbist_busy), 64'd1);
    pd_en = 1'b0;
    cyc();
    check("abort_flags", 64'({mbist_busy, mbist_done, mbist_fail}), 64'b011);
`else
    mbist_start = 1'b1;
    cyc();
    mbist_start = 1'b0;
    cyc();
    check("bist_absent",
          64'({mbist_busy, mbist_done, mbist_fail, mbist_fail_addr}), 64'd0);
    check("bist_absent_ready", 64'(req_ready), 64'd1);
`endif

    cyc(); cyc();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
